udp_tx_framer: RTL and testbench
================================

// Module: udp_tx_framer
// PURPOSE
//   Transmit-side counterpart of the UDP receive parser. Store-and-forward framer: buffers one
//   application payload, counts its length, then emits an 8-byte UDP header followed by the payload.
//   Sits between the application (payload source) and the IP transmit builder.
//   Header: {src_port, dst_port, length = 8 + payload bytes, checksum = 16'h0000}.
//   All 16-bit header fields are sent MSB byte first.
// PARAMETERS
//   DATA_WIDTH   8    stream byte width (only 8 supported)
//   MAX_PAYLOAD  256  payload buffer depth in bytes; power of 2, <= 65527
//   CNT_WIDTH    9    payload counter width; must hold MAX_PAYLOAD (clog2(MAX_PAYLOAD)+1)
// PORTS
//   clk            in   1   clock
//   rst_n          in   1   synchronous active-low reset
//   s_axis_tdata   in   8   payload byte from application
//   s_axis_tvalid  in   1   payload beat valid
//   s_axis_tlast   in   1   last payload byte
//   s_axis_tuser   in   32  {src_port[31:16], dst_port[15:0]}; sampled on first beat only
//   s_axis_tready  out  1   framer accepts payload
//   m_axis_tdata   out  8   UDP datagram byte (header then payload)
//   m_axis_tvalid  out  1   datagram beat valid
//   m_axis_tlast   out  1   last datagram byte
//   m_axis_tuser   out  16  UDP length (8 + payload bytes); stable for the whole datagram
//   m_axis_tready  in   1   downstream accepts
//   oversize_drop  out  1   1-cycle pulse when an oversize payload is discarded
// BEHAVIOUR
// - Reset (rst_n=0 at posedge): state S_IDLE, counters 0, s_axis_tready=0 during reset,
//   m_axis_tvalid/tlast/oversize_drop=0, m_axis_tdata/tuser=0. Buffer contents are not cleared.
// - Beat transfer: tvalid & tready high at posedge. Master outputs are registered.
// - Master stability: while m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata/tlast/tuser hold.
// - States:
//   S_IDLE    s_tready=1. First beat: latch tuser ports, write byte at addr 0, cnt=1.
//             If tlast: go to S_HEADER. Else: go to S_STORE.
//   S_STORE   s_tready=1. Each beat writes buf[cnt] and increments cnt.
//             Beat with tlast: go to S_HEADER.
//             Beat without tlast while cnt==MAX_PAYLOAD: go to S_DROP.
//   S_HEADER  s_tready=0. Emit 8 bytes in order: src_hi, src_lo, dst_hi, dst_lo, len_hi, len_lo,
//             00, 00, with len = 16'd8 + cnt. After the 8th beat is accepted: go to S_PAYLOAD.
//   S_PAYLOAD s_tready=0. Emit buf[0..cnt-1]; m_tlast=1 on byte cnt-1.
//             Last beat accepted: go to S_IDLE.
//   S_DROP    s_tready=1. Discard beats until tlast. On the tlast beat: oversize_drop=1 for
//             1 cycle, go to S_IDLE. Nothing is emitted for this packet.
// - Timing:
//   * First header byte has m_tvalid=1 in the cycle after the payload tlast beat is accepted.
//   * Consecutive datagram beats are gap-free when m_tready=1.
//   * After the final datagram beat, s_tready returns to 1 on the next cycle. No overlap between
//     packets (single buffer).
// - Size limits:
//   * Payload of exactly MAX_PAYLOAD bytes is legal.
//   * A payload always has >= 1 byte (tlast on the first beat means 1 byte).
// - s_axis_tuser on non-first beats is ignored; m_axis_tuser is updated when S_HEADER is entered.
// - Reset mid-packet (any state) aborts the partial packet: no tlast is emitted and no
//   oversize_drop pulse. The next packet after release is framed correctly.
// TESTING
// 1. Payload AA BB CC DD, tuser=32'h1234_61D4, m_tready=1 -> out 12 34 61 D4 00 0C 00 00 AA BB CC DD;
//    tlast on DD; m_tuser=16'h000C.
// 2. Same packet, random m_tready -> identical byte sequence; outputs stable while stalled;
//    s_tready=0 from the header through the last beat.
// 3. 1-byte payload 5A -> 9 beats, length bytes 00 09, tlast on 5A.
// 4. MAX_PAYLOAD=16: 16-byte payload -> length 0x0018, all bytes emitted.
//    17-byte payload -> no m_tvalid, one oversize_drop pulse on its tlast; next 2-byte packet framed
//    normally.
// 5. rst_n=0 while header byte 3 is pending -> m_tvalid=0 after reset; following packet correct.
// 6. Two back-to-back packets with s_tvalid held high -> each header uses its own first-beat tuser;
//    both datagrams correct and in order.

Source files
------------

// File: rtl/udp_tx_framer.sv
// udp_tx_framer: store-and-forward UDP framer that buffers one payload and then emits
// an 8-byte UDP header (zero checksum) followed by the buffered payload.
module udp_tx_framer #(
    parameter int DATA_WIDTH  = 8,
    parameter int MAX_PAYLOAD = 256,
    parameter int CNT_WIDTH   = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    input  logic [31:0]           s_axis_tuser,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic [15:0]           m_axis_tuser,
    input  logic                  m_axis_tready,
    output logic                  oversize_drop
);
    localparam int AW = $clog2(MAX_PAYLOAD);
    localparam logic [CNT_WIDTH-1:0] C_MAX = CNT_WIDTH'(MAX_PAYLOAD);

    typedef enum logic [2:0] {S_IDLE, S_STORE, S_HEADER, S_PAYLOAD, S_DROP} state_t;

    state_t                r_state, w_next;
    logic [DATA_WIDTH-1:0] r_buf [MAX_PAYLOAD];
    logic [CNT_WIDTH-1:0]  r_cnt, r_rd, w_cnt_d, w_rd_nxt;
    logic [31:0]           r_ports, w_ports_d;
    logic [3:0]            r_hidx;
    logic [DATA_WIDTH-1:0] r_m_tdata, w_hdr_byte;
    logic [15:0]           r_m_tuser;
    logic [63:0]           w_hdr_word;
    logic                  r_m_tvalid, r_m_tlast, r_drop;
    logic                  w_s_fire, w_m_fire, w_drop, w_enter_hdr, w_wr_en;
    logic [AW-1:0]         w_wr_addr;

    assign s_axis_tready = rst_n && (r_state == S_IDLE || r_state == S_STORE || r_state == S_DROP);
    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tvalid = r_m_tvalid;
    assign m_axis_tlast  = r_m_tlast;
    assign m_axis_tuser  = r_m_tuser;
    assign oversize_drop = r_drop;

    assign w_s_fire    = s_axis_tvalid && s_axis_tready;
    assign w_m_fire    = r_m_tvalid && m_axis_tready;
    assign w_cnt_d     = (r_state == S_IDLE) ? CNT_WIDTH'(1) : r_cnt + 1'b1;
    assign w_ports_d   = (r_state == S_IDLE) ? s_axis_tuser : r_ports;
    assign w_rd_nxt    = r_rd + 1'b1;
    assign w_enter_hdr = (r_state != S_HEADER) && (w_next == S_HEADER);
    assign w_wr_en     = w_s_fire && (r_state == S_IDLE || (r_state == S_STORE && r_cnt != C_MAX));
    assign w_wr_addr   = (r_state == S_IDLE) ? '0 : r_cnt[AW-1:0];
    // Header byte i sits at bits [63-8i -: 8]; shifting by 8*(7-i) brings it to the bottom.
    assign w_hdr_word  = {r_ports, r_m_tuser, 16'h0000};
    assign w_hdr_byte  = DATA_WIDTH'(w_hdr_word >> {~r_hidx[2:0], 3'b000});

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_drop = 1'b0;
        case (r_state)
            S_IDLE:    if (w_s_fire) w_next = s_axis_tlast ? S_HEADER : S_STORE;
            S_STORE: begin
                // A beat arriving with the buffer already full makes the payload oversize.
                if (w_s_fire && r_cnt == C_MAX) begin
                    w_next = s_axis_tlast ? S_IDLE : S_DROP;
                    w_drop = s_axis_tlast;
                end else if (w_s_fire && s_axis_tlast) begin
                    w_next = S_HEADER;
                end
            end
            S_HEADER:  if (w_m_fire && r_hidx == 4'd8) w_next = S_PAYLOAD;
            S_PAYLOAD: if (w_m_fire && r_m_tlast) w_next = S_IDLE;
            S_DROP: begin
                w_next = (w_s_fire && s_axis_tlast) ? S_IDLE : S_DROP;
                w_drop = w_s_fire && s_axis_tlast;
            end
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) r_buf[w_wr_addr] <= s_axis_tdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_ports <= '0;
        end else if (w_s_fire && r_state == S_IDLE) begin
            r_cnt   <= w_cnt_d;
            r_ports <= s_axis_tuser;
        end else if (w_s_fire && r_state == S_STORE && r_cnt != C_MAX) begin
            r_cnt   <= w_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tuser  <= '0;
            r_drop     <= 1'b0;
            r_hidx     <= '0;
            r_rd       <= '0;
        end else begin
            r_drop <= w_drop;
            if (w_enter_hdr) begin
                r_m_tvalid <= 1'b1;
                r_m_tlast  <= 1'b0;
                r_m_tdata  <= w_ports_d[31:24];
                r_m_tuser  <= 16'd8 + 16'(w_cnt_d);
                r_hidx     <= 4'd1;
                r_rd       <= '0;
            end else if (w_m_fire && r_state == S_HEADER && r_hidx != 4'd8) begin
                r_m_tdata <= w_hdr_byte;
                r_hidx    <= r_hidx + 4'd1;
            end else if (w_m_fire && (r_state == S_HEADER || !r_m_tlast)) begin
                r_m_tdata <= r_buf[r_rd[AW-1:0]];
                r_m_tlast <= (w_rd_nxt == r_cnt);
                r_rd      <= w_rd_nxt;
            end else if (w_m_fire) begin
                r_m_tvalid <= 1'b0;
                r_m_tlast  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_udp_tx_framer.sv
// tb_udp_tx_framer: randomized bench for udp_tx_framer against a queue-based datagram model.
module tb_udp_tx_framer;
    localparam int MAXP = 16;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {logic [7:0] d; logic l; logic [15:0] u;} beat_t;

    logic        clk, rst_n;
    logic [7:0]  s_axis_tdata, m_axis_tdata;
    logic        s_axis_tvalid, s_axis_tlast, s_axis_tready;
    logic [31:0] s_axis_tuser;
    logic        m_axis_tvalid, m_axis_tlast, m_axis_tready, oversize_drop;
    logic [15:0] m_axis_tuser;

    int    n_checks = 0, n_fail = 0, exp_drops = 0, rdy_mode = 0;
    beat_t exp_q[$];
    beat_t mon_e;
    bq_t   got_log;
    logic  prev_stall = 0, prev_last = 0;
    logic [25:0] prev_out = '0;

    udp_tx_framer #(.DATA_WIDTH(8), .MAX_PAYLOAD(MAXP), .CNT_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
        .s_axis_tuser(s_axis_tuser), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
        .m_axis_tuser(m_axis_tuser), .m_axis_tready(m_axis_tready), .oversize_drop(oversize_drop)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Datagram = header {src, dst, 8+len, 0} MSB first, then payload; oversize yields only a drop.
    task automatic model_pkt(input bq_t d, input logic [31:0] tu);
        beat_t b;
        logic [15:0] len;
        logic [63:0] hdr;
        if (d.size() > MAXP) begin
            exp_drops++;
            return;
        end
        len = 16'(d.size() + 8);
        hdr = {tu, len, 16'h0000};
        for (int i = 0; i < 8; i++) begin
            b.d = hdr[63-8*i -: 8];
            b.l = 1'b0;
            b.u = len;
            exp_q.push_back(b);
        end
        for (int i = 0; i < d.size(); i++) begin
            b.d = d[i];
            b.l = (i == d.size() - 1);
            b.u = len;
            exp_q.push_back(b);
        end
    endtask

    task automatic send_pkt(input bq_t d, input logic [31:0] tu, input bit gaps, input bit hold);
        logic ok;
        int   n;
        for (int i = 0; i < d.size(); i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                s_axis_tvalid = 0;
                @(posedge clk); #1;
            end
            s_axis_tdata  = d[i];
            s_axis_tvalid = 1;
            s_axis_tlast  = (i == d.size() - 1);
            s_axis_tuser  = (i == 0) ? tu : $urandom;
            n = 0;
            do begin
                @(negedge clk);
                ok = s_axis_tready;
                @(posedge clk); #1;
                n++;
            end while (!ok && n < 2000);
            if (!ok) chk("s_accept_timeout", 0, 1);
        end
        if (!hold) s_axis_tvalid = 0;
        model_pkt(d, tu);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || exp_drops != 0) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_beats_left", exp_q.size(), 0);
        chk("drain_drops_left", exp_drops, 0);
        @(posedge clk); #1;
    endtask

    task automatic cmp_log(input string tag, input bq_t exp);
        chk({tag, "_count"}, got_log.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got_log.size(); i++) chk(tag, got_log[i], exp[i]);
    endtask

    initial begin
        m_axis_tready = 0;
        forever begin
            @(posedge clk); #1;
            if (rdy_mode == 0)      m_axis_tready = 1;
            else if (rdy_mode == 1) m_axis_tready = 1'($urandom_range(0, 1));
            else if (rdy_mode == 2) m_axis_tready = 0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) chk("stall_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata}, prev_out);
            if (prev_last) chk("s_tready_after_last", s_axis_tready, 1);
            if (m_axis_tvalid) chk("s_tready_busy", s_axis_tready, 0);
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) chk("unexpected_beat", 1, 0);
                else begin
                    mon_e = exp_q.pop_front();
                    chk("m_tdata", m_axis_tdata, mon_e.d);
                    chk("m_tlast", m_axis_tlast, mon_e.l);
                    chk("m_tuser", m_axis_tuser, mon_e.u);
                end
                got_log.push_back(m_axis_tdata);
            end
            if (oversize_drop) begin
                chk("drop_expected", exp_drops != 0, 1);
                if (exp_drops != 0) exp_drops--;
            end
        end
        prev_stall = rst_n && m_axis_tvalid && !m_axis_tready;
        prev_last  = rst_n && m_axis_tvalid && m_axis_tready && m_axis_tlast;
        prev_out   = {m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata};
    end

    initial begin
        bq_t p, e;
        int  n;
        bit  hold;
        rst_n = 0; s_axis_tvalid = 0; s_axis_tdata = 0; s_axis_tlast = 0; s_axis_tuser = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_tready", s_axis_tready, 0);
        chk("rst_m_tvalid", m_axis_tvalid, 0);
        chk("rst_m_tlast", m_axis_tlast, 0);
        chk("rst_drop", oversize_drop, 0);
        chk("rst_m_tdata", m_axis_tdata, 0);
        chk("rst_m_tuser", m_axis_tuser, 0);
        @(posedge clk); #1;
        rst_n = 1;

        e = '{8'h12, 8'h34, 8'h61, 8'hD4, 8'h00, 8'h0C, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        p = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        got_log.delete();
        send_pkt(p, 32'h1234_61D4, 0, 0);
        drain();
        cmp_log("t1_byte", e);

        rdy_mode = 1;
        got_log.delete();
        send_pkt(p, 32'h1234_61D4, 1, 0);
        drain();
        cmp_log("t2_byte", e);

        rdy_mode = 0;
        got_log.delete();
        p = '{8'h5A};
        send_pkt(p, 32'h1234_61D4, 0, 0);
        drain();
        e = '{8'h12, 8'h34, 8'h61, 8'hD4, 8'h00, 8'h09, 8'h00, 8'h00, 8'h5A};
        cmp_log("t3_byte", e);

        p.delete();
        for (int i = 0; i < MAXP; i++) p.push_back(8'($urandom));
        send_pkt(p, 32'hA5A5_0042, 0, 0);
        drain();
        p.push_back(8'h77);
        got_log.delete();
        send_pkt(p, 32'h0101_0202, 0, 0);
        drain();
        chk("t4_oversize_silent", got_log.size(), 0);
        p = '{8'h01, 8'h02};
        send_pkt(p, 32'hBEEF_CAFE, 0, 0);
        drain();

        rdy_mode = 3;
        m_axis_tready = 0;
        p = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_pkt(p, 32'h0A0B_0C0D, 0, 0);
        n = 0;
        while (!m_axis_tvalid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t5_header_valid", m_axis_tvalid, 1);
        m_axis_tready = 1;
        repeat (3) @(posedge clk);
        #1;
        m_axis_tready = 0;
        rst_n = 0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("t5_rst_tvalid", m_axis_tvalid, 0);
        chk("t5_rst_tlast", m_axis_tlast, 0);
        chk("t5_rst_s_tready", s_axis_tready, 0);
        rst_n = 1;
        rdy_mode = 0;
        p = '{8'hC0, 8'hFF, 8'hEE};
        send_pkt(p, 32'h2222_3333, 0, 0);
        drain();

        got_log.delete();
        p = '{8'h01, 8'h02, 8'h03};
        send_pkt(p, 32'h1111_2222, 0, 1);
        p = '{8'h0A, 8'h0B};
        send_pkt(p, 32'h3333_4444, 0, 0);
        drain();
        e = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h00, 8'h0B, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03,
              8'h33, 8'h33, 8'h44, 8'h44, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h0A, 8'h0B};
        cmp_log("t6_byte", e);

        for (int k = 0; k < 30; k++) begin
            rdy_mode = $urandom_range(0, 1);
            p.delete();
            n = $urandom_range(1, MAXP + 2);
            for (int i = 0; i < n; i++) p.push_back(8'($urandom));
            hold = (k != 29) && ($urandom_range(0, 3) == 0);
            send_pkt(p, $urandom, 1'($urandom_range(0, 1)), hold);
            if (!hold) drain();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
